receiver_system: RTL and testbench

UART receive path, the counterpart of `transmitter_system`.
- Oversamples the serial `rx` line at 16× the baud rate and recovers 8N1 frames: one start bit, 8 data bits LSB first, one stop bit.
- Presents each received byte with a one-cycle `rx_done` strobe, or a one-cycle `frame_err` strobe on a bad stop bit.
- Sits between the board RX pin and the consumer logic.
- Defaults match the transmitter: 100 MHz clock, divisor 326, about 19200 baud.

---
 rtl/uart_pkg.sv | 10 +
 rtl/baud_tick_gen.sv | 25 ++
 rtl/receiver_system.sv | 125 ++++++++++++
 tb/tb_receiver_system.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default constants
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int UART_CLK_DIV    = 326;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running oversample tick generator
module baud_tick_gen #(
  parameter int CLK_DIV = 326
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/receiver_system.sv
// rtl/receiver_system.sv - 16x oversampling 8N1 UART receiver
module receiver_system
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int            SW     = $clog2(OVERSAMPLE);
  localparam int            NW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  logic                 w_tick, w_fall;
  rx_state_t            r_state, w_next;
  logic [SW-1:0]        r_s_cnt;
  logic [NW-1:0]        r_n_cnt;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_done, r_err;

  baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (w_tick)
  );

  // Synchronizer and edge-history flops reset high so release never looks like a start edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_s2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_next = START;
      START:   if (w_tick && r_s_cnt == S_MID) w_next = r_rx_s2 ? IDLE : DATA;
      DATA:    if (w_tick && r_s_cnt == S_LAST && r_n_cnt == N_LAST) w_next = STOP;
      STOP:    if (w_tick && r_s_cnt == S_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: if (w_fall) r_s_cnt <= '0;
        START: if (w_tick) begin
          if (r_s_cnt == S_MID) begin
            r_s_cnt <= '0;
            r_n_cnt <= '0;
          end else begin
            r_s_cnt <= r_s_cnt + 1'b1;
          end
        end
        DATA: if (w_tick) begin
          if (r_s_cnt == S_LAST) begin
            r_shift <= {r_rx_s2, r_shift[DATA_BITS-1:1]};
            r_s_cnt <= '0;
            if (r_n_cnt != N_LAST) r_n_cnt <= r_n_cnt + 1'b1;
          end else begin
            r_s_cnt <= r_s_cnt + 1'b1;
          end
        end
        STOP: if (w_tick) begin
          if (r_s_cnt == S_LAST) begin
            if (r_rx_s2) begin
              r_data <= r_shift;
              r_done <= 1'b1;
            end else begin
              r_err  <= 1'b1;
            end
            r_s_cnt <= '0;
          end else begin
            r_s_cnt <= r_s_cnt + 1'b1;
          end
        end
        default: r_s_cnt <= '0;
      endcase
    end
  end

  assign data_out  = r_data;
  assign rx_done   = r_done;
  assign frame_err = r_err;

endmodule

// File: tb/tb_receiver_system.sv
// tb/tb_receiver_system.sv - directed self-checking bench for receiver_system
module tb_receiver_system;

  localparam int CLK_DIV = 4;
  localparam int BP      = CLK_DIV * 16;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       rx_done, frame_err, busy;

  int         n_chk = 0, n_err = 0;
  int         done_cnt = 0, err_cnt = 0, cap_n = 0;
  logic [7:0] cap [0:31];
  bit         both_seen = 1'b0;
  int         d0, e0, c0;
  logic [7:0] frame_c3;

  always #5 clock = ~clock;

  receiver_system #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clock    (clock),
    .reset    (rst_n),
    .rx       (rx),
    .data_out (data_out),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always @(negedge clock) begin
    if (rx_done) begin
      done_cnt++;
      if (cap_n < 32) cap[cap_n] = data_out;
      cap_n++;
    end
    if (frame_err) err_cnt++;
    if (rx_done && frame_err) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BP) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_data", data_out, 8'h00);
    chk("rst_done", rx_done, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (BP) @(negedge clock);

    send_frame(8'h55, 1'b1);
    repeat (8) @(negedge clock);
    chk("single_data", data_out, 8'h55);
    chk("single_done", done_cnt, 1);
    chk("single_ferr", err_cnt, 0);
    chk("single_busy", busy, 1'b0);

    d0 = done_cnt; c0 = cap_n;
    send_frame(8'hAA, 1'b1);
    send_frame(8'h0F, 1'b1);
    repeat (8) @(negedge clock);
    chk("b2b_done", done_cnt - d0, 2);
    chk("b2b_first", cap[c0], 8'hAA);
    chk("b2b_second", cap[c0+1], 8'h0F);
    chk("b2b_data", data_out, 8'h0F);

    d0 = done_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clock);
    chk("glitch_busy_hi", busy, 1'b1);
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (BP) @(negedge clock);
    chk("glitch_busy_lo", busy, 1'b0);
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_ferr", err_cnt - e0, 0);

    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'h33, 1'b0);
    repeat (3 * BP) @(negedge clock);
    chk("ferr_count", err_cnt - e0, 1);
    chk("ferr_done", done_cnt - d0, 1);
    chk("ferr_data", data_out, 8'h55);
    chk("ferr_break_busy", busy, 1'b0);
    rx = 1'b1;
    repeat (BP) @(negedge clock);
    chk("ferr_after_break", err_cnt - e0, 1);

    d0 = done_cnt; e0 = err_cnt;
    frame_c3 = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(frame_c3[i]);
    rx = frame_c3[4];
    repeat (BP / 2) @(negedge clock);
    chk("midrst_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clock);
    rx = 1'b1;
    repeat (4) @(negedge clock);
    rst_n = 1'b1;
    repeat (BP) @(negedge clock);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_no_ferr", err_cnt - e0, 0);
    send_frame(8'hC3, 1'b1);
    repeat (8) @(negedge clock);
    chk("midrst_c3", data_out, 8'hC3);
    chk("midrst_c3_done", done_cnt - d0, 1);

    d0 = done_cnt; c0 = cap_n;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    repeat (8) @(negedge clock);
    chk("seq_done", done_cnt - d0, 3);
    chk("seq_00", cap[c0], 8'h00);
    chk("seq_ff", cap[c0+1], 8'hFF);
    chk("seq_a5", cap[c0+2], 8'hA5);
    chk("seq_data", data_out, 8'hA5);

    chk("never_both", both_seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
